// File: rtl/cp0.sv
// Coprocessor-0: holds SR, Cause and EPC, decides interrupt/exception entry
// in the M stage and supplies EPC for eret.
module cp0 (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_in,
   output logic [31:0] cp0_out,
   input  logic [31:0] vpc,
   input  logic        bd_in,
   input  logic [4:0]  exc_code_in,
   input  logic [5:0]  hw_int,
   input  logic        exl_clr,
   output logic [31:0] epc_out,
   output logic        req
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic        wr_sr;
   logic        wr_epc;
   logic        unused_cp0_in;

   assign int_req = !exl && ie && ((hw_int & im) != '0);
   assign exc_req = !exl && (exc_code_in != '0);
   assign req     = int_req || exc_req;

   assign wr_sr  = en && !req && (cp0_addr == ADDR_SR);
   assign wr_epc = en && !req && (cp0_addr == ADDR_EPC);

   // Only IM/EXL/IE are implemented in SR; remaining write-data bits are dropped.
   assign unused_cp0_in = ^{cp0_in[31:16], cp0_in[9:2]};

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= hw_int;
         if (req) begin
            exl      <= 1'b1;
            bd       <= bd_in;
            exc_code <= int_req ? 5'd0 : exc_code_in;
            epc      <= bd_in ? (vpc - 32'd4) : vpc;
         end else begin
            if (wr_sr) begin
               im  <= cp0_in[15:10];
               ie  <= cp0_in[0];
               exl <= cp0_in[1];
            end
            if (wr_epc)
               epc <= cp0_in;
            // eret overrides an SR write for EXL only
            if (exl_clr)
               exl <= 1'b0;
         end
      end
   end

   always_comb begin
      cp0_out = '0;
      unique case (cp0_addr)
         ADDR_SR:    cp0_out = {16'h0000, im, 8'h00, exl, ie};
         ADDR_CAUSE: cp0_out = {bd, 15'h0000, ip, 3'b000, exc_code, 2'b00};
         ADDR_EPC:   cp0_out = epc;
         default:    cp0_out = '0;
      endcase
   end

   assign epc_out = epc;

endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus randomized traffic
// compared against a word-level model of SR/Cause/EPC.
module tb_cp0;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_in;
   logic [31:0] cp0_out;
   logic [31:0] vpc;
   logic        bd_in;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        exl_clr;
   logic [31:0] epc_out;
   logic        req;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [31:0] m_sr, m_cause, m_epc;

   cp0 dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .cp0_addr    (cp0_addr),
      .cp0_in      (cp0_in),
      .cp0_out     (cp0_out),
      .vpc         (vpc),
      .bd_in       (bd_in),
      .exc_code_in (exc_code_in),
      .hw_int      (hw_int),
      .exl_clr     (exl_clr),
      .epc_out     (epc_out),
      .req         (req)
   );

   always #5 clk = ~clk;

   function automatic logic m_int();
      return (m_sr[1] == 1'b0) && (m_sr[0] == 1'b1) && (({26'd0, hw_int} & (m_sr >> 10) & 32'h3F) != 0);
   endfunction

   function automatic logic m_req();
      return m_int() || ((m_sr[1] == 1'b0) && (exc_code_in != 0));
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   // Advance one clock edge, updating the model from the inputs seen at that edge.
   task automatic step();
      logic [31:0] nsr, ncause, nepc;
      nsr    = m_sr;
      nepc   = m_epc;
      ncause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
      if (m_req()) begin
         nsr    = nsr | 32'h2;
         ncause = (ncause & 32'h0000_FC00) | (bd_in ? 32'h8000_0000 : 32'h0)
                  | (m_int() ? 32'h0 : ({27'd0, exc_code_in} << 2));
         nepc   = bd_in ? vpc - 32'd4 : vpc;
      end else begin
         if (en && cp0_addr == 5'd12) nsr  = cp0_in & 32'h0000_FC03;
         if (en && cp0_addr == 5'd14) nepc = cp0_in;
         if (exl_clr) nsr = nsr & ~32'h2;
      end
      if (reset) begin
         nsr = 0; ncause = 0; nepc = 0;
      end
      @(posedge clk);
      m_sr = nsr; m_cause = ncause; m_epc = nepc;
      #1;
   endtask

   task automatic idle_inputs();
      reset = 0; en = 0; cp0_addr = 0; cp0_in = 0; vpc = 0;
      bd_in = 0; exc_code_in = 0; hw_int = 0; exl_clr = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      reset = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; en = 1; cp0_addr = 14; cp0_in = 32'hDEAD_BEEF;
      exc_code_in = 10; vpc = 32'h5000; hw_int = 6'h07;
      step();
      idle_inputs();
      for (int a = 12; a <= 14; a++) begin
         cp0_addr = 5'(a); #1;
         n_checks++;
         if (cp0_out !== 32'h0) $display("FAIL reset_read%0d got %h exp 00000000", a, cp0_out);
         else n_pass++;
      end
      n_checks++;
      if (req !== 1'b0) $display("FAIL reset_req got %b exp 0", req); else n_pass++;
      n_checks++;
      if (epc_out !== 32'h0) $display("FAIL reset_epc got %h exp 00000000", epc_out); else n_pass++;
   endtask

   task automatic test_interrupt();
      do_reset();
      en = 1; cp0_addr = 12; cp0_in = 32'h0000_0401;
      step();
      en = 0; hw_int = 6'b000001; vpc = 32'h3004; bd_in = 0; #1;
      n_checks++;
      if (req !== 1'b1) $display("FAIL int_req got %b exp 1", req); else n_pass++;
      step();
      cp0_addr = 12; #1;
      n_checks++;
      if (cp0_out !== 32'h0000_0403) $display("FAIL int_sr got %h exp 00000403", cp0_out); else n_pass++;
      cp0_addr = 13; #1;
      n_checks++;
      if (cp0_out !== 32'h0000_0400) $display("FAIL int_cause got %h exp 00000400", cp0_out); else n_pass++;
      cp0_addr = 14; #1;
      n_checks++;
      if (cp0_out !== 32'h0000_3004 || epc_out !== 32'h0000_3004)
         $display("FAIL int_epc got %h/%h exp 00003004", cp0_out, epc_out);
      else n_pass++;
      n_checks++;
      if (req !== 1'b0) $display("FAIL int_exl_block got %b exp 0", req); else n_pass++;
   endtask

   task automatic test_delay_slot();
      do_reset();
      exc_code_in = 10; vpc = 32'h3010; bd_in = 1; #1;
      n_checks++;
      if (req !== 1'b1) $display("FAIL ds_req got %b exp 1", req); else n_pass++;
      step();
      idle_inputs(); cp0_addr = 13; #1;
      n_checks++;
      if (cp0_out !== 32'h8000_0028) $display("FAIL ds_cause got %h exp 80000028", cp0_out); else n_pass++;
      n_checks++;
      if (epc_out !== 32'h0000_300C) $display("FAIL ds_epc got %h exp 0000300c", epc_out); else n_pass++;
      do_reset();
      exc_code_in = 4; vpc = 32'h0000_0002; bd_in = 1;
      step();
      idle_inputs(); #1;
      n_checks++;
      if (epc_out !== 32'hFFFF_FFFE) $display("FAIL ds_wrap got %h exp fffffffe", epc_out); else n_pass++;
   endtask

   task automatic test_priority();
      do_reset();
      en = 1; cp0_addr = 12; cp0_in = 32'h0000_0801;
      step();
      en = 0; hw_int = 6'b000001; exc_code_in = 12; vpc = 32'h100;
      step();
      idle_inputs(); cp0_addr = 13; #1;
      n_checks++;
      if (cp0_out[6:2] !== 5'd12) $display("FAIL prio_masked got %0d exp 12", cp0_out[6:2]); else n_pass++;
      do_reset();
      en = 1; cp0_addr = 12; cp0_in = 32'h0000_0801;
      step();
      en = 0; hw_int = 6'b000010; exc_code_in = 12; vpc = 32'h100;
      step();
      idle_inputs(); cp0_addr = 13; #1;
      n_checks++;
      if (cp0_out !== 32'h0000_0800) $display("FAIL prio_int got %h exp 00000800", cp0_out); else n_pass++;
   endtask

   task automatic test_eret();
      do_reset();
      exc_code_in = 8; vpc = 32'h200;
      step();
      #1;
      n_checks++;
      if (req !== 1'b0) $display("FAIL eret_block got %b exp 0", req); else n_pass++;
      exl_clr = 1; #1;
      n_checks++;
      if (req !== 1'b0) $display("FAIL eret_same_cycle got %b exp 0", req); else n_pass++;
      step();
      exl_clr = 0; cp0_addr = 12; #1;
      n_checks++;
      if (cp0_out !== 32'h0) $display("FAIL eret_sr got %h exp 00000000", cp0_out); else n_pass++;
      n_checks++;
      if (req !== 1'b1) $display("FAIL eret_reassert got %b exp 1", req); else n_pass++;
      step();
      exc_code_in = 0; en = 1; cp0_addr = 12; cp0_in = 32'hFFFF_FC03; exl_clr = 1;
      step();
      idle_inputs(); cp0_addr = 12; #1;
      n_checks++;
      if (cp0_out !== 32'h0000_FC01) $display("FAIL eret_vs_mtc0 got %h exp 0000fc01", cp0_out); else n_pass++;
   endtask

   task automatic test_collision();
      do_reset();
      exc_code_in = 5; vpc = 32'h4000; en = 1; cp0_addr = 14; cp0_in = 32'h1234;
      step();
      idle_inputs(); #1;
      n_checks++;
      if (epc_out !== 32'h0000_4000) $display("FAIL coll_epc got %h exp 00004000", epc_out); else n_pass++;
      do_reset();
      en = 1; cp0_addr = 13; cp0_in = 32'hFFFF_FFFF;
      step();
      idle_inputs(); cp0_addr = 13; #1;
      n_checks++;
      if (cp0_out !== 32'h0) $display("FAIL coll_cause_ro got %h exp 00000000", cp0_out); else n_pass++;
   endtask

   task automatic test_random();
      logic [4:0] codes [8];
      logic [4:0] addrs [4];
      codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
      do_reset();
      for (int i = 0; i < 400; i++) begin
         addrs       = '{5'd12, 5'd13, 5'd14, 5'($urandom)};
         reset       = ($urandom_range(0, 49) == 0);
         en          = ($urandom_range(0, 2) == 0);
         cp0_addr    = addrs[$urandom_range(0, 3)];
         cp0_in      = $urandom;
         vpc         = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
         bd_in       = 1'($urandom);
         exc_code_in = codes[$urandom_range(0, 7)];
         hw_int      = {3'b000, 3'($urandom)};
         exl_clr     = ($urandom_range(0, 3) == 0);
         #1;
         n_checks++;
         if (req !== m_req()) $display("FAIL rnd_req[%0d] got %b exp %b", i, req, m_req()); else n_pass++;
         n_checks++;
         if (cp0_out !== m_read(cp0_addr))
            $display("FAIL rnd_read[%0d] addr %0d got %h exp %h", i, cp0_addr, cp0_out, m_read(cp0_addr));
         else n_pass++;
         n_checks++;
         if (epc_out !== m_epc) $display("FAIL rnd_epc[%0d] got %h exp %h", i, epc_out, m_epc); else n_pass++;
         step();
      end
   endtask

   initial begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_interrupt();
      test_delay_slot();
      test_priority();
      test_eret();
      test_collision();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
